// File: rtl/gnr_ctrl_pkg.sv
// Shared definitions for the gene-regulatory-network attractor sequencer:
// the controller state encoding and the default counter width.
package gnr_ctrl_pkg;

    localparam int GNR_DEFAULT_CW = 16;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_LOAD = 4'd1,
        S_P1A  = 4'd2,
        S_P1B  = 4'd3,
        S_C1   = 4'd4,
        S_P2A  = 4'd5,
        S_C2   = 4'd6,
        S_R3   = 4'd7,
        S_ADV  = 4'd8,
        S_C3   = 4'd9,
        S_P3A  = 4'd10,
        S_P3B  = 4'd11,
        S_DONE = 4'd12
    } gnr_state_t;

endpackage

// File: rtl/gnr_step_counter.sv
// Up-counter with clear, load and increment. o_hit reports whether the value
// the counter holds after this cycle's increment equals i_limit, so a state
// that increments can decide on the post-increment count in the same cycle.
module gnr_step_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_inc,
    input  logic [CW-1:0] i_limit,
    output logic [CW-1:0] o_count,
    output logic          o_hit
);

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_after;

    // Value seen after this cycle's increment, used for the limit flag
    always_comb begin
        if (i_inc) begin
            w_after = r_count + ONE;
        end else begin
            w_after = r_count;
        end
    end

    assign o_hit   = (w_after == i_limit);
    assign o_count = r_count;

    // Count register: clear beats load beats increment
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= {CW{1'b0}};
        end else if (i_clr) begin
            r_count <= {CW{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc) begin
            r_count <= r_count + ONE;
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// Floyd cycle-detection sequencer for one GRN simulation instance. It loads
// the initial state into the dual-copy nodes, steps the half-rate tortoise
// (s0) and full-rate hare (s1), and reports transient length, attractor
// period and the first attractor state.
module gnr_attractor_ctrl
    import gnr_ctrl_pkg::*;
#(
    parameter int N_NODES   = 8,
    parameter int CW        = GNR_DEFAULT_CW,
    parameter int MAX_STEPS = (2 ** CW) - 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] init_vec,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [CW-1:0]      transient,
    output logic [CW-1:0]      period,
    output logic [N_NODES-1:0] attractor
);

    localparam logic [CW-1:0] LIMIT = CW'(MAX_STEPS);

    gnr_state_t r_state;
    gnr_state_t w_next_state;

    logic               w_eq;
    logic               w_clr;
    logic               w_timeout;
    logic               w_i_load;
    logic               w_i_inc;
    logic               w_i_hit;
    logic [CW-1:0]      w_i_load_val;
    logic [CW-1:0]      w_unused_iter_count;
    logic               w_lam_inc;
    logic               w_lam_hit;
    logic [CW-1:0]      w_lam_count;
    logic               w_mu_inc;
    logic               w_mu_hit;
    logic [CW-1:0]      w_mu_count;

    logic               r_reset_nos;
    logic               r_start_s0;
    logic               r_start_s1;
    logic               r_busy;
    logic               r_done;
    logic               r_timeout;
    logic [N_NODES-1:0] r_init_state;
    logic [CW-1:0]      r_transient;
    logic [CW-1:0]      r_period;
    logic [N_NODES-1:0] r_attractor;

    assign w_eq = (s0_vec == s1_vec);

    // The iteration counter doubles as the advance counter: preloading it
    // with LIMIT-lambda makes it reach LIMIT after exactly lambda ADV cycles.
    assign w_i_load_val = LIMIT - w_lam_count;

    gnr_step_counter #(.CW(CW)) u_iter (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_clr),
        .i_load     (w_i_load),
        .i_load_val (w_i_load_val),
        .i_inc      (w_i_inc),
        .i_limit    (LIMIT),
        .o_count    (w_unused_iter_count),
        .o_hit      (w_i_hit)
    );

    gnr_step_counter #(.CW(CW)) u_lambda (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_clr),
        .i_load     (1'b0),
        .i_load_val ({CW{1'b0}}),
        .i_inc      (w_lam_inc),
        .i_limit    (LIMIT),
        .o_count    (w_lam_count),
        .o_hit      (w_lam_hit)
    );

    gnr_step_counter #(.CW(CW)) u_mu (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_clr),
        .i_load     (1'b0),
        .i_load_val ({CW{1'b0}}),
        .i_inc      (w_mu_inc),
        .i_limit    (LIMIT),
        .o_count    (w_mu_count),
        .o_hit      (w_mu_hit)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and counter control; equality is checked before any limit
    always_comb begin
        w_next_state = r_state;
        w_clr        = 1'b0;
        w_timeout    = 1'b0;
        w_i_load     = 1'b0;
        w_i_inc      = 1'b0;
        w_lam_inc    = 1'b0;
        w_mu_inc     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_LOAD;
                    w_clr        = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_LOAD: w_next_state = S_P1A;
            S_P1A:  w_next_state = S_P1B;
            S_P1B:  w_next_state = S_C1;
            S_C1: begin
                w_i_inc = 1'b1;
                if (w_eq) begin
                    w_next_state = S_P2A;
                end else if (w_i_hit) begin
                    w_next_state = S_DONE;
                    w_timeout    = 1'b1;
                end else begin
                    w_next_state = S_P1A;
                end
            end
            S_P2A:  w_next_state = S_C2;
            S_C2: begin
                w_lam_inc = 1'b1;
                if (w_eq) begin
                    w_next_state = S_R3;
                end else if (w_lam_hit) begin
                    w_next_state = S_DONE;
                    w_timeout    = 1'b1;
                end else begin
                    w_next_state = S_P2A;
                end
            end
            S_R3: begin
                w_i_load     = 1'b1;
                w_next_state = S_ADV;
            end
            S_ADV: begin
                w_i_inc = 1'b1;
                if (w_i_hit) begin
                    w_next_state = S_C3;
                end else begin
                    w_next_state = S_ADV;
                end
            end
            S_C3: begin
                if (w_eq) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_P3A;
                end
            end
            S_P3A:  w_next_state = S_P3B;
            S_P3B: begin
                w_mu_inc = 1'b1;
                if (w_mu_hit) begin
                    w_next_state = S_DONE;
                    w_timeout    = 1'b1;
                end else begin
                    w_next_state = S_C3;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Node pulses and status decoded from the state being entered, so they are
    // registered yet line up with the state they belong to
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reset_nos <= 1'b0;
            r_start_s0  <= 1'b0;
            r_start_s1  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_reset_nos <= (w_next_state == S_LOAD) || (w_next_state == S_R3);
            r_start_s0  <= w_next_state inside {S_P1A, S_P1B, S_P3A, S_P3B};
            r_start_s1  <= w_next_state inside {S_P1A, S_P1B, S_P2A, S_ADV, S_P3A};
            r_busy      <= (w_next_state != S_IDLE);
            r_done      <= (w_next_state == S_DONE);
        end
    end

    // Captured initial state, held for the node loads in LOAD and R3
    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_state <= {N_NODES{1'b0}};
        end else if (w_clr) begin
            r_init_state <= init_vec;
        end else begin
            r_init_state <= r_init_state;
        end
    end

    // Results change only on entry to DONE; a timeout forces them to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout   <= 1'b0;
            r_transient <= {CW{1'b0}};
            r_period    <= {CW{1'b0}};
            r_attractor <= {N_NODES{1'b0}};
        end else if (w_next_state == S_DONE) begin
            r_timeout   <= w_timeout;
            r_transient <= w_timeout ? {CW{1'b0}} : w_mu_count;
            r_period    <= w_timeout ? {CW{1'b0}} : w_lam_count;
            r_attractor <= w_timeout ? {N_NODES{1'b0}} : s0_vec;
        end else begin
            r_timeout   <= r_timeout;
            r_transient <= r_transient;
            r_period    <= r_period;
            r_attractor <= r_attractor;
        end
    end

    assign reset_nos  = r_reset_nos;
    assign init_state = r_init_state;
    assign start_s0   = r_start_s0;
    assign start_s1   = r_start_s1;
    assign busy       = r_busy;
    assign done       = r_done;
    assign timeout    = r_timeout;
    assign transient  = r_transient;
    assign period     = r_period;
    assign attractor  = r_attractor;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Bench for gnr_attractor_ctrl: two controllers (default limit and a limit
// of 4), each driving a behavioural node array whose update function is a
// lookup table. Expected results come from walking the function sequence.
module tb_gnr_attractor_ctrl;

    localparam int NN        = 8;
    localparam int CWB       = 16;
    localparam int BIG_MAX   = 65535;
    localparam int SMALL_MAX = 4;
    localparam int BOUND     = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic           startv [2] = '{1'b0, 1'b0};
    logic [NN-1:0]  initv  [2] = '{8'h00, 8'h00};
    logic [NN-1:0]  s0v    [2] = '{8'h00, 8'h00};
    logic [NN-1:0]  s1v    [2] = '{8'h00, 8'h00};
    logic           pass   [2] = '{1'b1, 1'b1};
    logic           rn     [2];
    logic           s0p    [2];
    logic           s1p    [2];
    logic           busy   [2];
    logic           done   [2];
    logic           tmo    [2];
    logic [CWB-1:0] trans  [2];
    logic [CWB-1:0] per    [2];
    logic [NN-1:0]  attr   [2];
    logic [NN-1:0]  inits  [2];
    logic [NN-1:0]  f_tab  [256];

    int n_tests  = 0;
    int n_fail   = 0;
    int last_cyc = 0;

    always #5 clk = ~clk;

    gnr_attractor_ctrl #(.N_NODES(NN), .CW(CWB)) u_dut_big (
        .clk(clk), .rst(rst), .start(startv[0]), .init_vec(initv[0]),
        .s0_vec(s0v[0]), .s1_vec(s1v[0]), .reset_nos(rn[0]), .init_state(inits[0]),
        .start_s0(s0p[0]), .start_s1(s1p[0]), .busy(busy[0]), .done(done[0]),
        .timeout(tmo[0]), .transient(trans[0]), .period(per[0]), .attractor(attr[0])
    );

    gnr_attractor_ctrl #(.N_NODES(NN), .CW(CWB), .MAX_STEPS(SMALL_MAX)) u_dut_small (
        .clk(clk), .rst(rst), .start(startv[1]), .init_vec(initv[1]),
        .s0_vec(s0v[1]), .s1_vec(s1v[1]), .reset_nos(rn[1]), .init_state(inits[1]),
        .start_s0(s0p[1]), .start_s1(s1p[1]), .busy(busy[1]), .done(done[1]),
        .timeout(tmo[1]), .transient(trans[1]), .period(per[1]), .attractor(attr[1])
    );

    // Behavioural nodes: hare steps on every start_s1, tortoise on every other start_s0
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rn[k]) begin
                s0v[k]  <= inits[k];
                s1v[k]  <= inits[k];
                pass[k] <= 1'b1;
            end else begin
                if (s1p[k]) s1v[k] <= f_tab[s1v[k]];
                if (s0p[k]) begin
                    if (pass[k]) s0v[k] <= f_tab[s0v[k]];
                    pass[k] <= ~pass[k];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Walk x0, f(x0), ... until a state repeats: first repeat index gives mu, gap gives lambda
    task automatic ref_model(input logic [NN-1:0] x0, output int mu, output int lam,
                             output int meet, output logic [NN-1:0] att);
        int            first_seen [256];
        logic [NN-1:0] x;
        int            k;
        for (int j = 0; j < 256; j++) first_seen[j] = -1;
        x = x0;
        k = 0;
        while (first_seen[x] < 0) begin
            first_seen[x] = k;
            x = f_tab[x];
            k++;
        end
        mu  = first_seen[x];
        lam = k - mu;
        att = x0;
        for (int j = 0; j < mu; j++) att = f_tab[att];
        meet = lam;
        while (meet < mu) meet += lam;
    endtask

    task automatic set_identity();
        for (int j = 0; j < 256; j++) f_tab[j] = 8'(j);
    endtask

    task automatic set_mod8();
        set_identity();
        for (int j = 0; j < 8; j++) f_tab[j] = 8'((j + 1) % 8);
    endtask

    // Run one job; poke > 0 raises start again in that cycle while busy
    task automatic run_job(input int inst, input logic [NN-1:0] x0, input int max_steps, input int poke);
        int            mu, lam, meet, cyc, rn_cnt, adv, exp_cyc;
        logic [NN-1:0] att;
        logic          exp_to, fin;
        ref_model(x0, mu, lam, meet, att);
        exp_to  = (meet > max_steps) || (mu >= max_steps);
        exp_cyc = 3 * meet + 3 * lam + 3 * mu + 4;
        @(negedge clk);
        initv[inst]  = x0;
        startv[inst] = 1'b1;
        @(posedge clk);
        #1;
        startv[inst] = 1'b0;
        cyc    = 1;
        rn_cnt = 0;
        adv    = 0;
        fin    = 1'b0;
        while (!fin) begin
            chk("no_overlap", {31'd0, rn[inst] & (s0p[inst] | s1p[inst])}, 32'd0);
            if (rn[inst]) rn_cnt++;
            else if (rn_cnt == 2 && s1p[inst] && !s0p[inst]) adv++;
            if (cyc == poke) begin
                startv[inst] = 1'b1;
                initv[inst]  = ~x0;
            end else begin
                startv[inst] = 1'b0;
            end
            if (done[inst] || cyc >= BOUND) begin
                fin = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        last_cyc = cyc;
        chk("done_seen", {31'd0, done[inst]}, 32'd1);
        if (!exp_to) chk("latency", cyc, exp_cyc);
        if (!exp_to) chk("adv_pulses", adv, {16'd0, per[inst]});
        chk("timeout", {31'd0, tmo[inst]}, {31'd0, exp_to});
        chk("transient", {16'd0, trans[inst]}, exp_to ? 32'd0 : mu);
        chk("period", {16'd0, per[inst]}, exp_to ? 32'd0 : lam);
        chk("attractor", {24'd0, attr[inst]}, exp_to ? 32'd0 : {24'd0, att});
        chk("init_state", {24'd0, inits[inst]}, {24'd0, x0});
        @(posedge clk);
        #1;
        chk("busy_after_done", {31'd0, busy[inst]}, 32'd0);
        chk("done_one_cycle", {31'd0, done[inst]}, 32'd0);
    endtask

    task automatic check_idle_zero(input int inst);
        chk("idle_busy", {31'd0, busy[inst]}, 32'd0);
        chk("idle_done", {31'd0, done[inst]}, 32'd0);
        chk("idle_pulses", {29'd0, rn[inst], s0p[inst], s1p[inst]}, 32'd0);
        chk("idle_timeout", {31'd0, tmo[inst]}, 32'd0);
        chk("idle_results", {trans[inst], per[inst]}, 32'd0);
        chk("idle_vectors", {16'd0, attr[inst], inits[inst]}, 32'd0);
    endtask

    initial begin
        int            cyc, rn_cnt;
        logic          fin;
        logic [NN-1:0] x0;

        set_identity();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero(0);
        check_idle_zero(1);
        rst = 1'b0;

        // Fixed point
        set_identity();
        run_job(0, 8'h05, BIG_MAX, 0);
        chk("fixed_point_cycle", last_cyc, 32'd10);
        chk("fixed_point_attr", {24'd0, attr[0]}, 32'h05);

        // 0->1->2->3->2 with a start pulse while busy
        set_identity();
        f_tab[0] = 8'd1;
        f_tab[1] = 8'd2;
        f_tab[2] = 8'd3;
        f_tab[3] = 8'd2;
        run_job(0, 8'h00, BIG_MAX, 3);
        chk("chain_period", {16'd0, per[0]}, 32'd2);
        chk("chain_transient", {16'd0, trans[0]}, 32'd2);
        chk("chain_attr", {24'd0, attr[0]}, 32'd2);

        // Full 8-cycle ring
        set_mod8();
        run_job(0, 8'h05, BIG_MAX, 0);
        chk("ring_period", {16'd0, per[0]}, 32'd8);

        // Small limit: fixed point still fits, 8-ring does not
        set_identity();
        run_job(1, 8'h33, SMALL_MAX, 0);
        set_mod8();
        run_job(1, 8'h05, SMALL_MAX, 0);
        chk("small_timeout", {31'd0, tmo[1]}, 32'd1);

        // Random functional graphs on 16 states
        for (int t = 0; t < 8; t++) begin
            set_identity();
            for (int j = 0; j < 16; j++) f_tab[j] = 8'($urandom_range(0, 15));
            x0 = 8'($urandom_range(0, 15));
            run_job(0, x0, BIG_MAX, (t == 2) ? 5 : 0);
        end

        // Synchronous reset in the middle of ADV
        set_mod8();
        @(negedge clk);
        initv[0]  = 8'h03;
        startv[0] = 1'b1;
        @(posedge clk);
        #1;
        startv[0] = 1'b0;
        cyc    = 1;
        rn_cnt = 0;
        fin    = 1'b0;
        while (!fin) begin
            if (rn[0]) rn_cnt++;
            if (rn_cnt == 2 && s1p[0]) begin
                fin = 1'b1;
            end else if (cyc >= BOUND) begin
                fin = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        chk("reached_adv", {31'd0, s1p[0] & ~s0p[0] & busy[0]}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle_zero(0);
        rst = 1'b0;

        // Recovery after reset
        set_identity();
        for (int j = 0; j < 16; j++) f_tab[j] = 8'($urandom_range(0, 15));
        run_job(0, 8'($urandom_range(0, 15)), BIG_MAX, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
